// File: rtl/dm_responder.sv
// MEM-stage data-memory responder: a word-organised memory with programmable wait states.
// It stalls the pipeline until the response and supports byte/half/word little-endian access.
module dm_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        req_valid,
    input  logic        mwk,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        misalign
);
    // state | meaning
    // IDLE  | ready for a request
    // WAIT  | aligned access pending, counting down wait states
    // RESP  | response strobe cycle, pipeline released
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              l_mwk;
    logic              l_uns;
    logic [ADDR_W+1:0] l_addr;
    logic [31:0]       l_wdata;
    logic [1:0]        l_size;

    logic [31:0]       mem [2**ADDR_W];

    logic [ADDR_W-1:0] idx;
    logic              bad;
    logic              access;
    logic [3:0]        be;
    logic [31:0]       wd;
    logic [31:0]       word;
    logic [31:0]       shifted;
    logic [31:0]       ld;
    logic              unused_hi;

    // address bits above the word index alias onto the same location
    assign unused_hi = ^addr[31:ADDR_W+2];

    assign idx       = l_addr[ADDR_W+1:2];
    assign access    = (state == WAIT) && (cnt == 4'd0);
    assign req_ready = (state == IDLE);
    assign stall     = (state == WAIT) || ((state == IDLE) && req_valid);

    always_comb begin
        bad = 1'b0;
        case (size)
            2'b01:   bad = addr[0];
            2'b10:   bad = (addr[1:0] != 2'b00);
            2'b11:   bad = 1'b1;
            default: bad = 1'b0;
        endcase
    end

    always_comb begin
        be = 4'b0000;
        wd = '0;
        case (l_size)
            2'b00: begin
                be = 4'b0001 << l_addr[1:0];
                wd = {4{l_wdata[7:0]}};
            end
            2'b01: begin
                be = l_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{l_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = l_wdata;
            end
        endcase
    end

    assign word    = mem[idx];
    assign shifted = word >> {l_addr[1:0], 3'b000};

    always_comb begin
        ld = word;
        case (l_size)
            2'b00:   ld = {{24{~l_uns & shifted[7]}}, shifted[7:0]};
            2'b01:   ld = {{16{~l_uns & shifted[15]}}, shifted[15:0]};
            default: ld = word;
        endcase
    end

    // memory contents deliberately have no reset
    always_ff @(posedge clk) begin
        if (clear_n && access && l_mwk) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            rdata      <= '0;
            misalign   <= 1'b0;
            l_mwk      <= 1'b0;
            l_uns      <= 1'b0;
            l_addr     <= '0;
            l_wdata    <= '0;
            l_size     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        l_mwk   <= mwk;
                        l_uns   <= load_unsigned;
                        l_addr  <= addr[ADDR_W+1:0];
                        l_wdata <= wdata;
                        l_size  <= size;
                        if (bad) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            misalign   <= 1'b1;
                            rdata      <= '0;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        misalign   <= 1'b0;
                        rdata      <= l_mwk ? 32'd0 : ld;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
